// File: rtl/oai21_bank_pwr_seq.sv
// rtl/oai21_bank_pwr_seq.sv - OAI21 channel bank behind a power-domain sequencer with clamped registered outputs
module oai21_bank_pwr_seq #(
  parameter int NCH        = 8,
  parameter int SETTLE_CYC = 4,
  parameter int ISO_CYC    = 2,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in1,
  input  logic [NCH-1:0]    in2,
  input  logic [NCH-1:0]    in3,
  input  logic              vdd_ok,
  input  logic              vss_ok,
  input  logic              eval_en,
  input  logic              err_clr,
  output logic [NCH-1:0]    qn,
  output logic              qn_valid,
  output logic [1:0]        pwr_state,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err_sticky
);

  // One down-counter is shared by SETTLE and ISO, so it is sized for the longer of the two.
  localparam int CMAX  = (SETTLE_CYC > ISO_CYC) ? SETTLE_CYC : ISO_CYC;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LOAD    = CNT_W'(ISO_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2,
    ST_ISO    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]    qn_q, qn_d;
  logic              valid_q, valid_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              err_q, err_d;
  logic              drop_inc;
  logic              err_set;
  logic              pg;
  logic [NCH-1:0]    func;

  assign pg   = vdd_ok & vss_ok;
  assign func = (in1 | in2) & (~in2 | ~in3);

  // Sequencer next state; qn is forced to zero in every state except a healthy ON.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qn_d     = qn_q;
    valid_d  = valid_q;
    drop_inc = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_OFF: begin
        qn_d    = '0;
        valid_d = 1'b0;
        if (pg) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        qn_d    = '0;
        valid_d = 1'b0;
        if (!pg) begin
          state_d  = ST_OFF;
          drop_inc = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ON: begin
        if (!pg) begin
          state_d  = ST_ISO;
          cnt_d    = ISO_LOAD;
          qn_d     = '0;
          valid_d  = 1'b0;
          drop_inc = 1'b1;
          err_set  = eval_en;
        end else if (eval_en) begin
          qn_d    = func;
          valid_d = 1'b1;
        end
      end
      ST_ISO: begin
        qn_d    = '0;
        valid_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Saturating drop counter and sticky error; a new error wins over a clear.
  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (drop_inc && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      qn_q    <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qn_q    <= qn_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign qn         = qn_q;
  assign qn_valid   = valid_q;
  assign pwr_state  = state_q;
  assign drop_cnt   = drop_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_oai21_bank_pwr_seq.sv
// tb/tb_oai21_bank_pwr_seq.sv - randomized and directed bench for oai21_bank_pwr_seq against a behavioural model
module tb_oai21_bank_pwr_seq;

  localparam int NCH = 8;
  localparam int SC  = 4;
  localparam int IC  = 2;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] in1 = '0;
  logic [NCH-1:0] in2 = '0;
  logic [NCH-1:0] in3 = '0;
  logic           vdd_ok = 1'b0;
  logic           vss_ok = 1'b0;
  logic           eval_en = 1'b0;
  logic           err_clr = 1'b0;
  logic [NCH-1:0] qn;
  logic           qn_valid;
  logic [1:0]     pwr_state;
  logic [DW-1:0]  drop_cnt;
  logic           err_sticky;

  oai21_bank_pwr_seq #(.NCH(NCH), .SETTLE_CYC(SC), .ISO_CYC(IC), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3),
    .vdd_ok(vdd_ok), .vss_ok(vss_ok), .eval_en(eval_en), .err_clr(err_clr),
    .qn(qn), .qn_valid(qn_valid), .pwr_state(pwr_state),
    .drop_cnt(drop_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 OFF, 1 SETTLE, 2 ON, 3 ISO; drops kept unbounded.
  int             m_mode, m_pg_edges, m_iso_edges, m_drops;
  logic [NCH-1:0] m_qn;
  logic           m_valid, m_err;
  logic [7:0]     truth;
  int             n_cmp, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] oai_ref(input logic [NCH-1:0] a, b, c);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = truth[{a[i], b[i], c[i]}];
    return r;
  endfunction

  task automatic model_edge();
    bit pg;
    pg = vdd_ok && vss_ok;
    if (rst) begin
      m_mode = 0; m_qn = '0; m_valid = 0; m_drops = 0; m_err = 0;
    end else begin
      bit set_err;
      set_err = 0;
      case (m_mode)
        0: if (pg) begin m_mode = 1; m_pg_edges = 0; end
        1: if (!pg) begin m_mode = 0; m_drops++; end
           else begin m_pg_edges++; if (m_pg_edges == SC) m_mode = 2; end
        2: if (!pg) begin
             m_mode = 3; m_iso_edges = 0; m_qn = '0; m_valid = 0; m_drops++;
             set_err = eval_en;
           end else if (eval_en) begin
             m_qn = oai_ref(in1, in2, in3); m_valid = 1;
           end
        default: begin m_iso_edges++; if (m_iso_edges == IC) m_mode = 0; end
      endcase
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  task automatic tick(input bit r, input bit pg, input bit ev, input bit clr,
                      input logic [NCH-1:0] a, input logic [NCH-1:0] b, input logic [NCH-1:0] c);
    int exp_drop;
    rst = r; vdd_ok = pg; vss_ok = pg; eval_en = ev; err_clr = clr;
    in1 = a; in2 = b; in3 = c;
    model_edge();
    @(posedge clk);
    #1;
    exp_drop = (m_drops > 3) ? 3 : m_drops;
    check_eq("pwr_state", 32'(pwr_state), 32'(m_mode));
    check_eq("qn", 32'(qn), 32'(m_qn));
    check_eq("qn_valid", 32'(qn_valid), 32'(m_valid));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check_eq("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  task automatic idle(input bit pg, input int n);
    for (int i = 0; i < n; i++) tick(0, pg, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    int pu_seq[5];
    bit r, pg, ev, clr;
    n_cmp = 0; n_bad = 0;
    truth = 8'h74;
    m_mode = 0; m_pg_edges = 0; m_iso_edges = 0; m_drops = 0;
    m_qn = '0; m_valid = 0; m_err = 0;
    pu_seq = '{1, 1, 1, 1, 2};
    @(posedge clk);
    #1;

    // Reset, then power-up with pg held.
    tick(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check_eq("reset_state", 32'(pwr_state), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      check_eq("pu_state", 32'(pwr_state), 32'(pu_seq[i]));
      check_eq("pu_qn", 32'(qn), 32'd0);
    end

    // Function sweep then hold.
    tick(0, 1, 1, 0, 8'hF0, 8'hCC, 8'hAA);
    check_eq("func_qn", 32'(qn), 32'h74);
    check_eq("func_valid", 32'(qn_valid), 32'd1);
    tick(0, 1, 0, 0, 8'h0F, 8'h33, 8'h55);
    check_eq("hold_qn", 32'(qn), 32'h74);

    // Drop during eval, then ISO lasts IC edges with pg held.
    tick(0, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("ff_qn", 32'(qn), 32'hFF);
    tick(0, 0, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("drop_state", 32'(pwr_state), 32'd3);
    check_eq("drop_err", 32'(err_sticky), 32'd1);
    check_eq("drop_qn", 32'(qn), 32'd0);
    tick(0, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("iso_hold", 32'(pwr_state), 32'd3);
    tick(0, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("iso_exit", 32'(pwr_state), 32'd0);

    // Drop during SETTLE, then a full settle.
    idle(1, 2);
    idle(0, 1);
    check_eq("settle_drop_state", 32'(pwr_state), 32'd0);
    check_eq("settle_drop_cnt", 32'(drop_cnt), 32'd2);
    idle(1, 5);
    check_eq("resettle_on", 32'(pwr_state), 32'd2);

    // New error with err_clr, then clear alone, then saturation.
    tick(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    check_eq("clr_vs_set", 32'(err_sticky), 32'd1);
    idle(0, 2);
    tick(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    check_eq("clr_alone", 32'(err_sticky), 32'd0);
    for (int k = 0; k < 2; k++) begin
      idle(1, 2);
      idle(0, 1);
    end
    check_eq("drop_sat", 32'(drop_cnt), 32'd3);

    // Reset while ON with qn=5A; other inputs active during rst.
    idle(1, 5);
    tick(0, 1, 1, 0, 8'h5A, 8'h00, 8'h00);
    check_eq("qn_5a", 32'(qn), 32'h5A);
    tick(1, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("rst_state", 32'(pwr_state), 32'd0);
    check_eq("rst_qn", 32'(qn), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    tick(1, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    check_eq("rst_hold", 32'(pwr_state), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 249) == 0);
      pg  = ($urandom_range(0, 14) != 0);
      ev  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 11) == 0);
      tick(r, pg, ev, clr, NCH'($urandom), NCH'($urandom), NCH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oai21_bank_pwr_seq.md
Name: oai21_bank_pwr_seq

Overview:
- Parametrised, clocked successor to the single OAI21X1 cell model: NCH independent channels, each computing qn = (in1 | in2) & (~in2 | ~in3).
- Adds a power-domain sequencer (OFF/SETTLE/ON/ISO), registered outputs, output clamping during bad power, and drop counting / sticky error reporting.
- Sits at the boundary of a switchable power domain and feeds always-on logic that must never see unclamped outputs.

Parameters:
- NCH, 8, number of channels (≥1)
- SETTLE_CYC, 4, consecutive power-good cycles required before entering ON (≥1)
- ISO_CYC, 2, cycles held in ISO before returning to OFF (≥1)
- DROP_W, 8, width of the saturating power-drop counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in1  in  NCH  channel input A
- in2  in  NCH  channel input B
- in3  in  NCH  channel input C
- vdd_ok  in  1  supply-good indication (1 = VDD good)
- vss_ok  in  1  ground-good indication (1 = VSS good)
- eval_en  in  1  sample inputs and update qn this cycle (honoured only in ON)
- err_clr  in  1  clears err_sticky
- qn  out  NCH  registered channel outputs
- qn_valid  out  1  qn holds a result computed in the current ON period
- pwr_state  out  2  current state: 0 OFF, 1 SETTLE, 2 ON, 3 ISO
- drop_cnt  out  DROP_W  saturating count of power drops seen in SETTLE or ON
- err_sticky  out  1  a drop occurred in ON while eval_en was high

Behaviour:
- Reset is synchronous and active-high. On a rst clock edge: pwr_state=OFF, qn=0, qn_valid=0, drop_cnt=0, err_sticky=0, settle counter=0. rst overrides all other inputs.
- pg = vdd_ok & vss_ok, sampled each rising edge.
- OFF:
  - qn=0, qn_valid=0.
  - pg=1 -> SETTLE; load settle counter with SETTLE_CYC-1.
- SETTLE:
  - qn=0, qn_valid=0.
  - pg=0 -> OFF and drop_cnt += 1.
  - pg=1 and counter==0 -> ON.
  - Otherwise the counter decrements.
  - Result: ON is reached exactly SETTLE_CYC edges after the first pg=1 edge in OFF. SETTLE_CYC=1 means OFF->SETTLE->ON on consecutive edges.
- ON:
  - If pg=1 and eval_en=1: qn <= func(in1,in2,in3) bitwise per channel, and qn_valid <= 1. Latency is 1 cycle from the eval_en edge.
  - If pg=1 and eval_en=0: qn and qn_valid hold.
  - If pg=0 -> ISO: qn <= 0, qn_valid <= 0, drop_cnt += 1, and the eval is ignored. If eval_en=1 on that same edge, also set err_sticky.
- ISO:
  - qn=0, qn_valid=0.
  - Counts ISO_CYC edges, then -> OFF regardless of pg.
  - Power returning during ISO does not shorten ISO.
- drop_cnt saturates at all-ones and never wraps.
- err_sticky:
  - Set has priority over err_clr on the same edge.
  - err_clr=1 with no set -> 0 on the next edge.
- qn is never nonzero outside ON. Transitions into ON start with qn=0 and qn_valid=0 until the first eval.
- pwr_state is registered and reflects the state after the edge.
- Inputs are ignored entirely outside ON.

Test Plan:
- Power-up: rst 1 cycle, then pg=1 held, SETTLE_CYC=4 -> pwr_state 0,1,1,1,1,2; ON on the 4th edge after the first pg edge; qn=0 and qn_valid=0 throughout.
- Function sweep: in ON, NCH=8, in1=8'b11110000, in2=8'b11001100, in3=8'b10101010 with eval_en=1 -> next cycle qn=8'b01110100 and qn_valid=1; with eval_en=0 the next cycle, qn holds.
- Drop in SETTLE: pg=1 for 2 cycles, then pg=0 -> pwr_state back to 0 and drop_cnt=1; a later full settle reaches ON normally.
- Drop during eval: in ON with qn=8'hFF and valid, pg=0 and eval_en=1 on the same edge -> state 3, qn=0, qn_valid=0, err_sticky=1, drop_cnt+1; after ISO_CYC=2 edges, state 0 even with pg=1 held.
- Sticky and saturation:
  - DROP_W=2: force 5 drops -> drop_cnt=3.
  - err_clr with a simultaneous new error -> err_sticky stays 1.
  - err_clr alone -> err_sticky=0.
- Reset mid-ON: rst=1 while ON with qn=8'h5A -> next edge all outputs 0 and pwr_state=0; vdd_ok/vss_ok/eval_en are ignored while rst=1.
